// File: rtl/dec_sched_pkg.sv
// Shared types and constants for the decompression job scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dec_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RUN,
        REPORT,
        DRAIN
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_SKIPPED = 2'b10;

    localparam int JOB_ID_W = 16;
    localparam int LEN_W    = 32;

    // Packed descriptor: job id, source and destination addresses, two lengths.
    function automatic int desc_width(input int addr_w);
        return JOB_ID_W + 2 * addr_w + 2 * LEN_W;
    endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// Synchronous FIFO holding packed job descriptors; head is visible combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is ignored while full (full is registered, so a same-cycle pop does not free a slot).
module sched_job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LW-1:0]    level_nxt;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt = level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Storage array carries no reset; only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/dec_job_scheduler.sv
// Queues decompression descriptors and issues them one at a time to axi_io, reporting status.
// Latency: enqueue at edge N into an idle system raises dec_start from N+1 to N+2.
// Backpressure: enq_ready low while the queue is full; completions hold until cmpl_ready.
module dec_job_scheduler #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int QUEUE_DEPTH        = 4,
    parameter int TMO_WIDTH          = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [15:0]                   enq_job_id,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] enq_src_addr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] enq_des_addr,
    input  logic [31:0]                   enq_comp_len,
    input  logic [31:0]                   enq_decomp_len,
    output logic                          dec_job_valid,
    output logic                          dec_start,
    output logic [15:0]                   dec_job_id,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] dec_src_addr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] dec_des_addr,
    output logic [31:0]                   dec_comp_len,
    output logic [31:0]                   dec_decomp_len,
    input  logic                          dec_done,
    input  logic                          dec_idle,
    input  logic [TMO_WIDTH-1:0]          timeout_cycles,
    output logic                          cmpl_valid,
    input  logic                          cmpl_ready,
    output logic [15:0]                   cmpl_job_id,
    output logic [1:0]                    cmpl_status,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_level,
    output logic                          busy
);

    import dec_sched_pkg::*;

    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int DESC_W = desc_width(AW);

    typedef struct packed {
        logic [15:0]   job_id;
        logic [AW-1:0] src_addr;
        logic [AW-1:0] des_addr;
        logic [31:0]   comp_len;
        logic [31:0]   decomp_len;
    } desc_t;

    desc_t                 enq_desc;
    desc_t                 head;
    logic [DESC_W-1:0]     head_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  timeout_hit;
    state_t                state;
    logic                  drain;
    logic [TMO_WIDTH-1:0]  wdog;

    assign enq_desc  = '{enq_job_id, enq_src_addr, enq_des_addr, enq_comp_len, enq_decomp_len};
    assign head      = desc_t'(head_dat);
    assign enq_ready = !fifo_full;
    assign push      = enq_valid && enq_ready;
    // Only pop when the decompressor reports idle and nothing is in flight.
    assign pop       = (state == IDLE) && !fifo_empty && dec_idle;
    assign busy      = (state != IDLE) || !fifo_empty;
    // Unsigned compare; >= also catches a limit lowered while a job is running.
    assign timeout_hit = (timeout_cycles != '0) && (wdog >= timeout_cycles - TMO_WIDTH'(1));

    sched_job_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (QUEUE_DEPTH),
        .LW    ($clog2(QUEUE_DEPTH) + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (enq_desc),
        .pop      (pop),
        .pop_dat  (head_dat),
        .level    (queue_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Job sequencing FSM with registered control, descriptor and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            drain          <= 1'b0;
            wdog           <= '0;
            dec_job_valid  <= 1'b0;
            dec_start      <= 1'b0;
            dec_job_id     <= '0;
            dec_src_addr   <= '0;
            dec_des_addr   <= '0;
            dec_comp_len   <= '0;
            dec_decomp_len <= '0;
            cmpl_valid     <= 1'b0;
            cmpl_job_id    <= '0;
            cmpl_status    <= ST_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        dec_job_id     <= head.job_id;
                        dec_src_addr   <= head.src_addr;
                        dec_des_addr   <= head.des_addr;
                        dec_comp_len   <= head.comp_len;
                        dec_decomp_len <= head.decomp_len;
                        if ((head.comp_len == '0) || (head.decomp_len == '0)) begin
                            state       <= REPORT;
                            cmpl_valid  <= 1'b1;
                            cmpl_job_id <= head.job_id;
                            cmpl_status <= ST_SKIPPED;
                        end else begin
                            state         <= ISSUE;
                            dec_job_valid <= 1'b1;
                            dec_start     <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    dec_job_valid <= 1'b0;
                    dec_start     <= 1'b0;
                    wdog          <= '0;
                    state         <= RUN;
                end
                RUN: begin
                    if (dec_done) begin
                        state       <= REPORT;
                        cmpl_valid  <= 1'b1;
                        cmpl_job_id <= dec_job_id;
                        cmpl_status <= ST_OK;
                        wdog        <= '0;
                    end else if (timeout_hit) begin
                        state       <= REPORT;
                        cmpl_valid  <= 1'b1;
                        cmpl_job_id <= dec_job_id;
                        cmpl_status <= ST_TIMEOUT;
                        drain       <= 1'b1;
                        wdog        <= '0;
                    end else if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                REPORT: begin
                    if (cmpl_ready) begin
                        cmpl_valid <= 1'b0;
                        state      <= drain ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    // A timed-out job may still be running; wait for axi_io to go idle.
                    if (dec_idle) begin
                        drain <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_job_scheduler.sv
module tb_dec_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enq_valid;
    logic        enq_ready;
    logic [15:0] enq_job_id;
    logic [63:0] enq_src_addr;
    logic [63:0] enq_des_addr;
    logic [31:0] enq_comp_len;
    logic [31:0] enq_decomp_len;
    logic        dec_job_valid;
    logic        dec_start;
    logic [15:0] dec_job_id;
    logic [63:0] dec_src_addr;
    logic [63:0] dec_des_addr;
    logic [31:0] dec_comp_len;
    logic [31:0] dec_decomp_len;
    logic        dec_done;
    logic        dec_idle;
    logic [31:0] timeout_cycles;
    logic        cmpl_valid;
    logic        cmpl_ready;
    logic [15:0] cmpl_job_id;
    logic [1:0]  cmpl_status;
    logic [2:0]  queue_level;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_job_scheduler #(
        .C_M_AXI_ADDR_WIDTH (64),
        .QUEUE_DEPTH        (4),
        .TMO_WIDTH          (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_job_id     (enq_job_id),
        .enq_src_addr   (enq_src_addr),
        .enq_des_addr   (enq_des_addr),
        .enq_comp_len   (enq_comp_len),
        .enq_decomp_len (enq_decomp_len),
        .dec_job_valid  (dec_job_valid),
        .dec_start      (dec_start),
        .dec_job_id     (dec_job_id),
        .dec_src_addr   (dec_src_addr),
        .dec_des_addr   (dec_des_addr),
        .dec_comp_len   (dec_comp_len),
        .dec_decomp_len (dec_decomp_len),
        .dec_done       (dec_done),
        .dec_idle       (dec_idle),
        .timeout_cycles (timeout_cycles),
        .cmpl_valid     (cmpl_valid),
        .cmpl_ready     (cmpl_ready),
        .cmpl_job_id    (cmpl_job_id),
        .cmpl_status    (cmpl_status),
        .queue_level    (queue_level),
        .busy           (busy)
    );

    // Advance one edge and settle; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [15:0] id, input logic [31:0] cl, input logic [31:0] dl);
        enq_job_id     = id;
        enq_src_addr   = 64'h1000 + 64'(id);
        enq_des_addr   = 64'h8000 + 64'(id);
        enq_comp_len   = cl;
        enq_decomp_len = dl;
    endtask

    task automatic enq(input logic [15:0] id, input logic [31:0] cl, input logic [31:0] dl);
        set_desc(id, cl, dl);
        enq_valid = 1'b1;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!dec_start && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!dec_start) begin
            errors++;
            $display("FAIL %s: dec_start never seen, got %b required 1", name, dec_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b required 1", enq_ready); end
        checks++; if (dec_start !== 1'b0 || dec_job_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_ctl: got %b%b required 00", dec_start, dec_job_valid); end
        checks++; if (cmpl_valid !== 1'b0 || cmpl_status !== 2'b00 || cmpl_job_id !== 16'h0) begin errors++; $display("FAIL reset_cmpl: got %b %b %h required 0 00 0000", cmpl_valid, cmpl_status, cmpl_job_id); end
        checks++; if (queue_level !== 3'd0 || busy !== 1'b0 || dec_job_id !== 16'h0) begin errors++; $display("FAIL reset_level_busy: got %0d %b %h required 0 0 0000", queue_level, busy, dec_job_id); end
        rst_n = 1'b1;
        tick();
        checks++; if (enq_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: got %b %b required 1 0", enq_ready, busy); end
    endtask

    task automatic test_single_job();
        int bad = 0;
        dec_idle = 1'b1; cmpl_ready = 1'b0; timeout_cycles = 32'd0;
        enq(16'h0011, 32'd100, 32'd400);
        checks++; if (queue_level !== 3'd1 || dec_start !== 1'b0) begin errors++; $display("FAIL single_after_enq: got lvl %0d start %b required 1 0", queue_level, dec_start); end
        tick();
        checks++; if (dec_start !== 1'b1 || dec_job_valid !== 1'b1) begin errors++; $display("FAIL single_start: got %b%b required 11", dec_start, dec_job_valid); end
        checks++; if (dec_job_id !== 16'h0011 || dec_src_addr !== 64'h1011 || dec_des_addr !== 64'h8011 || dec_comp_len !== 32'd100 || dec_decomp_len !== 32'd400) begin
            errors++; $display("FAIL single_fields: got %h %h %h %0d %0d required 0011 1011 8011 100 400", dec_job_id, dec_src_addr, dec_des_addr, dec_comp_len, dec_decomp_len);
        end
        for (int i = 0; i < 49; i++) begin
            tick();
            if (dec_start !== 1'b0 || dec_job_valid !== 1'b0 || cmpl_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_pulse: got %0d bad cycles required 0", bad); end
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        checks++; if (cmpl_valid !== 1'b1 || cmpl_job_id !== 16'h0011 || cmpl_status !== 2'b00) begin errors++; $display("FAIL single_cmpl: got %b %h %b required 1 0011 00", cmpl_valid, cmpl_job_id, cmpl_status); end
        cmpl_ready = 1'b1;
        tick();
        checks++; if (cmpl_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_handshake: got %b %b required 0 0", cmpl_valid, busy); end
    endtask

    task automatic test_skip();
        int starts = 0;
        cmpl_ready = 1'b0;
        enq(16'h0022, 32'd0, 32'd50);
        if (dec_start) starts++;
        tick();
        if (dec_start) starts++;
        checks++; if (cmpl_valid !== 1'b1 || cmpl_job_id !== 16'h0022 || cmpl_status !== 2'b10) begin errors++; $display("FAIL skip_cmpl: got %b %h %b required 1 0022 10", cmpl_valid, cmpl_job_id, cmpl_status); end
        cmpl_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dec_start) starts++;
        end
        checks++; if (starts != 0 || cmpl_valid !== 1'b0) begin errors++; $display("FAIL skip_no_start: got %0d starts cmpl %b required 0 0", starts, cmpl_valid); end
    endtask

    task automatic test_queue_full();
        logic [15:0] exp_id;
        dec_idle = 1'b0; cmpl_ready = 1'b1;
        for (int k = 0; k < 4; k++) enq(16'h0101 + 16'(k), 32'd8, 32'd16);
        checks++; if (enq_ready !== 1'b0 || queue_level !== 3'd4) begin errors++; $display("FAIL full_after4: got rdy %b lvl %0d required 0 4", enq_ready, queue_level); end
        set_desc(16'h0105, 32'd8, 32'd16);
        enq_valid = 1'b1;
        repeat (3) tick();
        checks++; if (enq_ready !== 1'b0 || queue_level !== 3'd4 || dec_start !== 1'b0) begin errors++; $display("FAIL full_hold: got rdy %b lvl %0d start %b required 0 4 0", enq_ready, queue_level, dec_start); end
        dec_idle = 1'b1;
        tick();
        checks++; if (dec_start !== 1'b1 || dec_job_id !== 16'h0101 || queue_level !== 3'd3 || enq_ready !== 1'b1) begin
            errors++; $display("FAIL full_first_pop: got start %b id %h lvl %0d rdy %b required 1 0101 3 1", dec_start, dec_job_id, queue_level, enq_ready);
        end
        tick();
        enq_valid = 1'b0;
        checks++; if (queue_level !== 3'd4) begin errors++; $display("FAIL full_fifth_accepted: got lvl %0d required 4", queue_level); end
        for (int k = 0; k < 5; k++) begin
            exp_id = 16'h0101 + 16'(k);
            if (k != 0) begin
                wait_start("full_order_start");
                checks++; if (dec_job_id !== exp_id) begin errors++; $display("FAIL full_order_issue: got %h required %h", dec_job_id, exp_id); end
            end
            repeat (2) tick();
            dec_done = 1'b1;
            tick();
            dec_done = 1'b0;
            checks++; if (cmpl_valid !== 1'b1 || cmpl_job_id !== exp_id || cmpl_status !== 2'b00) begin errors++; $display("FAIL full_order_cmpl: got %b %h %b required 1 %h 00", cmpl_valid, cmpl_job_id, cmpl_status, exp_id); end
            tick();
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int starts = 0;
        timeout_cycles = 32'd10; dec_idle = 1'b1; cmpl_ready = 1'b1;
        enq(16'h0033, 32'd64, 32'd256);
        tick();
        checks++; if (dec_start !== 1'b1 || dec_job_id !== 16'h0033) begin errors++; $display("FAIL tmo_start: got %b %h required 1 0033", dec_start, dec_job_id); end
        dec_idle = 1'b0;
        enq(16'h0034, 32'd64, 32'd256);
        n = 1;
        while (!cmpl_valid && n < 40) begin
            tick();
            n++;
        end
        checks++; if (cmpl_valid !== 1'b1 || n != 11) begin errors++; $display("FAIL tmo_latency: got valid %b after %0d edges required 1 after 11", cmpl_valid, n); end
        checks++; if (cmpl_job_id !== 16'h0033 || cmpl_status !== 2'b01) begin errors++; $display("FAIL tmo_status: got %h %b required 0033 01", cmpl_job_id, cmpl_status); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dec_start) starts++;
        end
        checks++; if (starts != 0 || queue_level !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL tmo_drain_hold: got starts %0d lvl %0d busy %b required 0 1 1", starts, queue_level, busy); end
        dec_idle = 1'b1;
        tick();
        checks++; if (dec_start !== 1'b0) begin errors++; $display("FAIL tmo_drain_exit: got %b required 0", dec_start); end
        tick();
        checks++; if (dec_start !== 1'b1 || dec_job_id !== 16'h0034) begin errors++; $display("FAIL tmo_next_start: got %b %h required 1 0034", dec_start, dec_job_id); end
        tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        checks++; if (cmpl_valid !== 1'b1 || cmpl_job_id !== 16'h0034 || cmpl_status !== 2'b00) begin errors++; $display("FAIL tmo_next_cmpl: got %b %h %b required 1 0034 00", cmpl_valid, cmpl_job_id, cmpl_status); end
        tick();
    endtask

    task automatic test_done_at_timeout();
        timeout_cycles = 32'd10; dec_idle = 1'b1; cmpl_ready = 1'b1;
        enq(16'h0044, 32'd10, 32'd20);
        tick();
        checks++; if (dec_start !== 1'b1) begin errors++; $display("FAIL tie_start: got %b required 1", dec_start); end
        repeat (10) tick();
        checks++; if (cmpl_valid !== 1'b0) begin errors++; $display("FAIL tie_early: got %b required 0", cmpl_valid); end
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        checks++; if (cmpl_valid !== 1'b1 || cmpl_job_id !== 16'h0044 || cmpl_status !== 2'b00) begin errors++; $display("FAIL tie_status: got %b %h %b required 1 0044 00", cmpl_valid, cmpl_job_id, cmpl_status); end
        tick();
        timeout_cycles = 32'd0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_no_drain: got busy %b required 0", busy); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        dec_idle = 1'b1; cmpl_ready = 1'b0; timeout_cycles = 32'd0;
        enq(16'h0055, 32'd5, 32'd9);
        enq(16'h0056, 32'd6, 32'd9);
        checks++; if (dec_start !== 1'b1 || dec_job_id !== 16'h0055 || queue_level !== 3'd1) begin errors++; $display("FAIL bp_start: got %b %h %0d required 1 0055 1", dec_start, dec_job_id, queue_level); end
        repeat (3) tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (cmpl_valid !== 1'b1 || cmpl_job_id !== 16'h0055 || cmpl_status !== 2'b00 || dec_start !== 1'b0 || dec_job_id !== 16'h0055 || dec_comp_len !== 32'd5) bad++;
            tick();
        end
        checks++; if (bad != 0 || queue_level !== 3'd1) begin errors++; $display("FAIL bp_stable: got %0d bad cycles lvl %0d required 0 1", bad, queue_level); end
        cmpl_ready = 1'b1;
        tick();
        checks++; if (cmpl_valid !== 1'b0 || dec_start !== 1'b0) begin errors++; $display("FAIL bp_handshake: got %b %b required 0 0", cmpl_valid, dec_start); end
        tick();
        checks++; if (dec_start !== 1'b1 || dec_job_id !== 16'h0056) begin errors++; $display("FAIL bp_next_start: got %b %h required 1 0056", dec_start, dec_job_id); end
        repeat (2) tick();
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        checks++; if (cmpl_valid !== 1'b1 || cmpl_job_id !== 16'h0056) begin errors++; $display("FAIL bp_next_cmpl: got %b %h required 1 0056", cmpl_valid, cmpl_job_id); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int bad = 0;
        dec_idle = 1'b1; cmpl_ready = 1'b1; timeout_cycles = 32'd0;
        enq(16'h0066, 32'd7, 32'd9);
        enq(16'h0067, 32'd7, 32'd9);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (enq_ready !== 1'b1 || queue_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_run_queue: got rdy %b lvl %0d busy %b required 1 0 0", enq_ready, queue_level, busy); end
        checks++; if (dec_start !== 1'b0 || dec_job_valid !== 1'b0 || dec_job_id !== 16'h0 || dec_comp_len !== 32'd0 || cmpl_valid !== 1'b0) begin
            errors++; $display("FAIL rst_run_outputs: got %b %b %h %0d %b required 0 0 0000 0 0", dec_start, dec_job_valid, dec_job_id, dec_comp_len, cmpl_valid);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dec_start !== 1'b0 || cmpl_valid !== 1'b0 || queue_level !== 3'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_run_discard: got %0d bad cycles required 0", bad); end
    endtask

    initial begin
        rst_n = 1'b0; enq_valid = 1'b0; dec_done = 1'b0; dec_idle = 1'b1;
        cmpl_ready = 1'b0; timeout_cycles = 32'd0;
        set_desc(16'h0, 32'd0, 32'd0);
        test_reset();
        test_single_job();
        test_skip();
        test_queue_full();
        test_timeout();
        test_done_at_timeout();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_job_scheduler.md
Name: dec_job_scheduler

Overview:
- Sequences decompression jobs into the single axi_io decompressor instance, which accepts exactly one job at a time.
- Host-side logic pushes job descriptors into an internal queue. The scheduler issues them one by one over axi_io's job_valid/start/done/idle controls.
- Each finished job is reported on a completion channel with a status code, including a watchdog timeout for hung jobs.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64: width of src/des addresses.
- QUEUE_DEPTH, 4: job queue entries; power of two, minimum 2.
- TMO_WIDTH, 32: width of the watchdog counter and timeout_cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock domain; rst_n is asynchronous and active-low.
- enq_valid  in  1  descriptor offered.
- enq_ready  out  1  queue can accept.
- enq_job_id  in  16  job tag.
- enq_src_addr  in  C_M_AXI_ADDR_WIDTH  compressed source address.
- enq_des_addr  in  C_M_AXI_ADDR_WIDTH  destination address.
- enq_comp_len  in  32  compressed byte length.
- enq_decomp_len  in  32  decompressed byte length.
- dec_job_valid  out  1  to axi_io job_valid.
- dec_start  out  1  to axi_io start.
- dec_job_id  out  16  issued job tag.
- dec_src_addr  out  C_M_AXI_ADDR_WIDTH  issued source address.
- dec_des_addr  out  C_M_AXI_ADDR_WIDTH  issued destination address.
- dec_comp_len  out  32  issued compressed length.
- dec_decomp_len  out  32  issued decompressed length.
- dec_done  in  1  from axi_io done (1-cycle pulse).
- dec_idle  in  1  from axi_io idle.
- timeout_cycles  in  TMO_WIDTH  watchdog limit; 0 disables the watchdog.
- cmpl_valid  out  1  completion record valid.
- cmpl_ready  in  1  completion consumer ready.
- cmpl_job_id  out  16  tag of the completed job.
- cmpl_status  out  2  00 OK, 01 TIMEOUT, 10 SKIPPED (zero length), 11 reserved.
- queue_level  out  $clog2(QUEUE_DEPTH)+1  number of queued entries.
- busy  out  1  state is not IDLE, or queue is non-empty.

Behaviour:
- Reset values: all outputs 0 except enq_ready=1. Queue empty, state IDLE, watchdog counter 0.
- Reset mid-operation discards all queued and in-flight jobs. No completion is produced for them.
- Queue:
  - Enqueue happens on enq_valid && enq_ready; enq_ready = (level != QUEUE_DEPTH).
  - When full, enq_ready stays 0 even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- IDLE:
  - If the queue is non-empty and dec_idle=1: pop the head into job registers.
  - If comp_len==0 or decomp_len==0, go to REPORT with SKIPPED. Otherwise go to ISSUE.
  - If dec_idle=0, nothing is popped.
- ISSUE (exactly 1 cycle): dec_job_valid=1 and dec_start=1, then go to RUN.
- Timing: a descriptor enqueued at edge N into an empty, idle system gives dec_start high between edges N+1 and N+2.
- RUN:
  - dec_job_valid=0. dec_* data fields stay stable from pop until leaving REPORT.
  - The watchdog increments each RUN cycle.
  - dec_done=1 → REPORT with OK.
  - Otherwise, if timeout_cycles!=0 and the counter reaches timeout_cycles-1 → REPORT with TIMEOUT and set the drain flag.
  - If dec_done and timeout coincide, dec_done wins (OK).
  - dec_done outside RUN is ignored.
- REPORT:
  - cmpl_valid=1 with cmpl_job_id and cmpl_status held stable until cmpl_ready.
  - On the handshake, go to DRAIN if the drain flag is set, else to IDLE.
  - The watchdog clears on leaving RUN.
- DRAIN (after TIMEOUT only): wait for dec_idle=1, clear the drain flag, go to IDLE. No pop occurs in this cycle.
- Back-to-back jobs: the next pop occurs no earlier than the cycle after the REPORT handshake.
- Arithmetic: the watchdog saturates at its all-ones value. Comparison is unsigned.

Decomposition:
- Package dec_sched_pkg:
  - state enum: IDLE, ISSUE, RUN, REPORT, DRAIN.
  - cmpl_status constants: ST_OK, ST_TIMEOUT, ST_SKIPPED.
  - Descriptor width constant: 16 + 2*C_M_AXI_ADDR_WIDTH + 64 bits.
- One sub-module, sched_job_fifo: synchronous FIFO holding packed descriptors, with registered level and full/empty outputs.

Test Plan:
- Single job (id 0x0011, comp_len 100, decomp_len 400, dec_idle=1) enqueued at edge N:
  - dec_start is a single-cycle pulse starting after edge N+1.
  - dec_done pulses 50 cycles later → cmpl_valid with id 0x0011, status 00.
- Enqueue 5 jobs with QUEUE_DEPTH=4 while dec_idle=0:
  - enq_ready drops after the 4th enqueue.
  - The 5th is accepted only after the first pop.
  - Completions come out in FIFO order.
- timeout_cycles=10, dec_done never asserted:
  - TIMEOUT completion 10 cycles after ISSUE.
  - With dec_idle held 0 for 20 cycles, no further dec_start occurs until dec_idle=1.
- Job with comp_len=0 → SKIPPED completion, dec_start never asserted.
- cmpl_ready held 0 for 30 cycles after dec_done → cmpl fields stable and no new dec_start until the handshake.
- Same-cycle events:
  - dec_done coinciding with the timeout cycle → status OK.
  - rst_n asserted during RUN → all outputs return to reset values and queue_level=0.
